// File: rtl/bram_tdp_be_pipe.sv
// bram_tdp_be_pipe: single-clock true-dual-port block RAM with per-byte write
// enables, per-port write modes, a 1- or 2-cycle read pipeline, read-valid
// strobes and same-address collision reporting with a fixed port priority.

module bram_tdp_be_pipe #(
    parameter int    SIZE     = 1024,
    parameter int    WIDTH    = 256,
    parameter int    BYTE_W   = 8,
    parameter int    READ_LAT = 1,
    parameter string WMODE_A  = "READ_FIRST",
    parameter string WMODE_B  = "READ_FIRST",
    parameter string PRIO     = "A"
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ena,
    input  logic                       enb,
    input  logic [WIDTH/BYTE_W-1:0]    wea,
    input  logic [WIDTH/BYTE_W-1:0]    web,
    input  logic [$clog2(SIZE)-1:0]    addra,
    input  logic [$clog2(SIZE)-1:0]    addrb,
    input  logic [WIDTH-1:0]           dia,
    input  logic [WIDTH-1:0]           dib,
    output logic [WIDTH-1:0]           doa,
    output logic [WIDTH-1:0]           dob,
    output logic                       vala,
    output logic                       valb,
    output logic                       coll
);

    localparam int NB = WIDTH / BYTE_W;

    // Mode decoding; anything unrecognised is rejected at elaboration below.
    localparam bit WF_A   = (WMODE_A == "WRITE_FIRST");
    localparam bit NC_A   = (WMODE_A == "NO_CHANGE");
    localparam bit WF_B   = (WMODE_B == "WRITE_FIRST");
    localparam bit NC_B   = (WMODE_B == "NO_CHANGE");
    localparam bit PRIO_B = (PRIO == "B");

    generate
        if (WIDTH % BYTE_W != 0) begin : g_bad_width
            $error("bram_tdp_be_pipe: WIDTH must be a multiple of BYTE_W");
        end
        if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_lat
            $error("bram_tdp_be_pipe: READ_LAT must be 1 or 2");
        end
        if (WMODE_A != "READ_FIRST" && WMODE_A != "WRITE_FIRST" && WMODE_A != "NO_CHANGE") begin : g_bad_wma
            $error("bram_tdp_be_pipe: illegal WMODE_A");
        end
        if (WMODE_B != "READ_FIRST" && WMODE_B != "WRITE_FIRST" && WMODE_B != "NO_CHANGE") begin : g_bad_wmb
            $error("bram_tdp_be_pipe: illegal WMODE_B");
        end
        if (PRIO != "A" && PRIO != "B") begin : g_bad_prio
            $error("bram_tdp_be_pipe: PRIO must be \"A\" or \"B\"");
        end
    endgenerate

    logic [WIDTH-1:0] mem [SIZE];

    logic             same_addr;
    logic [NB-1:0]    wa_eff;
    logic [NB-1:0]    wb_eff;
    logic [WIDTH-1:0] old_a;
    logic [WIDTH-1:0] old_b;
    logic [WIDTH-1:0] new_a;
    logic [WIDTH-1:0] new_b;
    logic [WIDTH-1:0] rdata_a;
    logic [WIDTH-1:0] rdata_b;
    logic             fire_a;
    logic             fire_b;
    logic             coll_next;

    logic             s1_val_a;
    logic             s1_val_b;
    logic [WIDTH-1:0] s1_data_a;
    logic [WIDTH-1:0] s1_data_b;
    logic             coll_q;

    // Resolve lane ownership on a shared address, build the stored words and pick each port's read word.
    always_comb begin
        same_addr = ena && enb && (addra == addrb);
        wa_eff    = ena ? wea : '0;
        wb_eff    = enb ? web : '0;
        if (same_addr) begin
            if (PRIO_B) begin
                wa_eff = wa_eff & ~wb_eff;
            end else begin
                wb_eff = wb_eff & ~wa_eff;
            end
        end

        old_a = mem[addra];
        old_b = mem[addrb];
        new_a = old_a;
        new_b = old_b;
        for (int i = 0; i < NB; i++) begin
            if (wa_eff[i]) begin
                new_a[i*BYTE_W +: BYTE_W] = dia[i*BYTE_W +: BYTE_W];
            end
            if (same_addr && wb_eff[i]) begin
                new_a[i*BYTE_W +: BYTE_W] = dib[i*BYTE_W +: BYTE_W];
            end
            if (wb_eff[i]) begin
                new_b[i*BYTE_W +: BYTE_W] = dib[i*BYTE_W +: BYTE_W];
            end
            if (same_addr && wa_eff[i]) begin
                new_b[i*BYTE_W +: BYTE_W] = dia[i*BYTE_W +: BYTE_W];
            end
        end

        // A port that only reads always sees the pre-write word, even if the
        // other port writes the same address this cycle.
        rdata_a   = (WF_A && (|wea)) ? new_a : old_a;
        rdata_b   = (WF_B && (|web)) ? new_b : old_b;
        fire_a    = ena && !(NC_A && (|wea));
        fire_b    = enb && !(NC_B && (|web));
        coll_next = same_addr && ((|wea) || (|web));
    end

    // Byte-lane writes into the array; lane sets are disjoint on a shared address, and reset blocks writes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NB; i++) begin
                if (wa_eff[i]) begin
                    mem[addra][i*BYTE_W +: BYTE_W] <= dia[i*BYTE_W +: BYTE_W];
                end
                if (wb_eff[i]) begin
                    mem[addrb][i*BYTE_W +: BYTE_W] <= dib[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // RAM read register: captures a read word only when the port produces a result, and the collision flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_val_a  <= 1'b0;
            s1_val_b  <= 1'b0;
            s1_data_a <= '0;
            s1_data_b <= '0;
            coll_q    <= 1'b0;
        end else begin
            s1_val_a <= fire_a;
            s1_val_b <= fire_b;
            if (fire_a) begin
                s1_data_a <= rdata_a;
            end
            if (fire_b) begin
                s1_data_b <= rdata_b;
            end
            coll_q <= coll_next;
        end
    end

    assign coll = coll_q;

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic             va_q;
            logic             vb_q;
            logic [WIDTH-1:0] da_q;
            logic [WIDTH-1:0] db_q;

            // Output register: forwards stage-1 results and holds the last word between valid pulses.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    va_q <= 1'b0;
                    vb_q <= 1'b0;
                    da_q <= '0;
                    db_q <= '0;
                end else begin
                    va_q <= s1_val_a;
                    vb_q <= s1_val_b;
                    if (s1_val_a) begin
                        da_q <= s1_data_a;
                    end
                    if (s1_val_b) begin
                        db_q <= s1_data_b;
                    end
                end
            end

            assign doa  = da_q;
            assign dob  = db_q;
            assign vala = va_q;
            assign valb = vb_q;
        end else begin : g_lat1
            assign doa  = s1_data_a;
            assign dob  = s1_data_b;
            assign vala = s1_val_a;
            assign valb = s1_val_b;
        end
    endgenerate

endmodule

// File: tb/tb_bram_tdp_be_pipe.sv
// tb_bram_tdp_be_pipe: three differently configured RAM instances share one
// stimulus stream. A directed vector table and short hand-written sequences
// check known answers; a behavioural model checks every cycle of every instance.

module tb_bram_tdp_be_pipe;

    localparam int RF = 0;
    localparam int WF = 1;
    localparam int NC = 2;

    logic        clk;
    logic        rst;
    logic        ena;
    logic        enb;
    logic [3:0]  wea;
    logic [3:0]  web;
    logic [3:0]  addra;
    logic [3:0]  addrb;
    logic [31:0] dia;
    logic [31:0] dib;

    logic [31:0] doa_o [3];
    logic [31:0] dob_o [3];
    logic        vala_o [3];
    logic        valb_o [3];
    logic        coll_o [3];

    // d1: latency 1, A write-first, B read-first, A wins
    bram_tdp_be_pipe #(.SIZE(16), .WIDTH(32), .BYTE_W(8), .READ_LAT(1),
                       .WMODE_A("WRITE_FIRST"), .WMODE_B("READ_FIRST"), .PRIO("A")) u_d1 (
        .clk(clk), .rst(rst), .ena(ena), .enb(enb), .wea(wea), .web(web),
        .addra(addra), .addrb(addrb), .dia(dia), .dib(dib),
        .doa(doa_o[0]), .dob(dob_o[0]), .vala(vala_o[0]), .valb(valb_o[0]), .coll(coll_o[0]));

    // d2: latency 1, A no-change, B write-first, B wins
    bram_tdp_be_pipe #(.SIZE(16), .WIDTH(32), .BYTE_W(8), .READ_LAT(1),
                       .WMODE_A("NO_CHANGE"), .WMODE_B("WRITE_FIRST"), .PRIO("B")) u_d2 (
        .clk(clk), .rst(rst), .ena(ena), .enb(enb), .wea(wea), .web(web),
        .addra(addra), .addrb(addrb), .dia(dia), .dib(dib),
        .doa(doa_o[1]), .dob(dob_o[1]), .vala(vala_o[1]), .valb(valb_o[1]), .coll(coll_o[1]));

    // d3: latency 2, A read-first, B no-change, A wins
    bram_tdp_be_pipe #(.SIZE(16), .WIDTH(32), .BYTE_W(8), .READ_LAT(2),
                       .WMODE_A("READ_FIRST"), .WMODE_B("NO_CHANGE"), .PRIO("A")) u_d3 (
        .clk(clk), .rst(rst), .ena(ena), .enb(enb), .wea(wea), .web(web),
        .addra(addra), .addrb(addrb), .dia(dia), .dib(dib),
        .doa(doa_o[2]), .dob(dob_o[2]), .vala(vala_o[2]), .valb(valb_o[2]), .coll(coll_o[2]));

    int cfg_lat    [3] = '{1, 1, 2};
    int cfg_wma    [3] = '{WF, NC, RF};
    int cfg_wmb    [3] = '{RF, WF, NC};
    bit cfg_prio_b [3] = '{1'b0, 1'b1, 1'b0};

    typedef struct {
        int          due;
        logic [31:0] data;
    } pend_t;

    logic [31:0] mmem [3][16];
    pend_t       qa [3][$];
    pend_t       qb [3][$];
    logic [31:0] e_doa [3];
    logic [31:0] e_dob [3];
    logic        e_vala [3];
    logic        e_valb [3];
    logic        e_coll [3];

    int cyc;
    int vectors;
    int miscompares;
    bit check_en;

    typedef struct {
        logic        rst, ena, enb;
        logic [3:0]  wea, web, addra, addrb;
        logic [31:0] dia, dib;
        logic        vala, valb, coll;
        logic [31:0] doa, dob;
    } vec_t;

    vec_t tbl [16];

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against a hung run
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: run did not reach the summary, got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic writePort(input int k, input bit portb);
        logic [3:0]  we;
        logic [3:0]  ad;
        logic [31:0] d;
        we = portb ? (enb ? web : 4'h0) : (ena ? wea : 4'h0);
        ad = portb ? addrb : addra;
        d  = portb ? dib : dia;
        for (int i = 0; i < 4; i++) begin
            if (we[i]) mmem[k][ad][8*i +: 8] = d[8*i +: 8];
        end
    endtask

    // Reference: writes applied lowest priority first so the winner overwrites shared lanes
    task automatic modelStep();
        logic [31:0] old_a;
        logic [31:0] old_b;
        pend_t       p;
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                qa[k].delete();
                qb[k].delete();
                e_vala[k] = 1'b0;
                e_valb[k] = 1'b0;
                e_coll[k] = 1'b0;
                e_doa[k]  = '0;
                e_dob[k]  = '0;
            end else begin
                old_a = mmem[k][addra];
                old_b = mmem[k][addrb];
                if (cfg_prio_b[k]) begin
                    writePort(k, 1'b0);
                    writePort(k, 1'b1);
                end else begin
                    writePort(k, 1'b1);
                    writePort(k, 1'b0);
                end
                if (ena && !(cfg_wma[k] == NC && wea != 4'h0)) begin
                    p.due  = cyc + cfg_lat[k] - 1;
                    p.data = (cfg_wma[k] == WF && wea != 4'h0) ? mmem[k][addra] : old_a;
                    qa[k].push_back(p);
                end
                if (enb && !(cfg_wmb[k] == NC && web != 4'h0)) begin
                    p.due  = cyc + cfg_lat[k] - 1;
                    p.data = (cfg_wmb[k] == WF && web != 4'h0) ? mmem[k][addrb] : old_b;
                    qb[k].push_back(p);
                end
                e_coll[k] = ena && enb && (addra == addrb) && (wea != 4'h0 || web != 4'h0);
                e_vala[k] = 1'b0;
                e_valb[k] = 1'b0;
                if (qa[k].size() > 0 && qa[k][0].due == cyc) begin
                    e_vala[k] = 1'b1;
                    e_doa[k]  = qa[k][0].data;
                    void'(qa[k].pop_front());
                end
                if (qb[k].size() > 0 && qb[k][0].due == cyc) begin
                    e_valb[k] = 1'b1;
                    e_dob[k]  = qb[k][0].data;
                    void'(qb[k].pop_front());
                end
            end
        end
    endtask

    task automatic checkOutput();
        logic [66:0] got;
        logic [66:0] exp;
        if (check_en) begin
            for (int k = 0; k < 3; k++) begin
                got = {vala_o[k], valb_o[k], coll_o[k], doa_o[k], dob_o[k]};
                exp = {e_vala[k], e_valb[k], e_coll[k], e_doa[k], e_dob[k]};
                vectors++;
                if (got !== exp) begin
                    miscompares++;
                    $display("[TB] FAIL model d%0d cyc %0d: got val=%b%b coll=%b doa=%h dob=%h, want val=%b%b coll=%b doa=%h dob=%h",
                             k + 1, cyc, vala_o[k], valb_o[k], coll_o[k], doa_o[k], dob_o[k],
                             e_vala[k], e_valb[k], e_coll[k], e_doa[k], e_dob[k]);
                end
            end
        end
    endtask

    task automatic checkVal(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, want %h", name, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic ea, input logic eb,
                                 input logic [3:0] wa, input logic [3:0] wb,
                                 input logic [3:0] aa, input logic [3:0] ab,
                                 input logic [31:0] da, input logic [31:0] db);
        rst   = r;
        ena   = ea;
        enb   = eb;
        wea   = wa;
        web   = wb;
        addra = aa;
        addrb = ab;
        dia   = da;
        dib   = db;
        @(posedge clk);
        modelStep();
        #1;
        checkOutput();
        cyc++;
        @(negedge clk);
    endtask

    // Test sequence: reset, fill, directed table, corner sequences, random traffic
    initial begin
        logic [31:0] v;
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        check_en    = 1'b1;
        for (int k = 0; k < 3; k++) begin
            e_doa[k] = '0; e_dob[k] = '0; e_vala[k] = 1'b0; e_valb[k] = 1'b0; e_coll[k] = 1'b0;
            for (int a = 0; a < 16; a++) mmem[k][a] = '0;
        end

        // Vectors: rst ena enb wea web addra addrb dia dib | vala valb coll doa dob  (instance d1)
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'd0, 4'd0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 4'hF, 4'h0, 4'd3, 4'd0, 32'h11223344, 32'h0,        1'b1, 1'b0, 1'b0, 32'h11223344, 32'h0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 4'h5, 4'h0, 4'd3, 4'd0, 32'hAABBCCDD, 32'h0,        1'b1, 1'b0, 1'b0, 32'h11BB33DD, 32'h0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'd3, 4'd0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 32'h11BB33DD, 32'h0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 4'hF, 4'h0, 4'd5, 4'd0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        32'h0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 4'hF, 4'h0, 4'd5, 4'd0, 32'hCAFEF00D, 32'h0,        1'b1, 1'b0, 1'b0, 32'hCAFEF00D, 32'h0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 4'h0, 4'hF, 4'd0, 4'd5, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 32'hCAFEF00D, 32'hCAFEF00D};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 4'h0, 4'hF, 4'd0, 4'd5, 32'h0,        32'hCAFEF00D, 1'b0, 1'b1, 1'b0, 32'hCAFEF00D, 32'h0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 4'hF, 4'h0, 4'd7, 4'd0, 32'h44332211, 32'h0,        1'b1, 1'b0, 1'b0, 32'h44332211, 32'h0};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 4'h3, 4'h6, 4'd7, 4'd7, 32'h11111111, 32'h22222222, 1'b1, 1'b1, 1'b1, 32'h44221111, 32'h44332211};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'd7, 4'd0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 32'h44221111, 32'h44332211};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 4'hF, 4'h0, 4'd2, 4'd0, 32'h5,        32'h0,        1'b1, 1'b0, 1'b0, 32'h5,        32'h44332211};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 4'hF, 4'h0, 4'd2, 4'd2, 32'h9,        32'h0,        1'b1, 1'b1, 1'b1, 32'h9,        32'h5};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 4'd0, 4'd2, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 32'h9,        32'h9};
        tbl[14] = '{1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4'd2, 4'd2, 32'h0,        32'h0,        1'b1, 1'b1, 1'b0, 32'h9,        32'h9};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'd0, 4'd0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h9,        32'h9};

        $display("[TB] reset");
        applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'd0, 4'd0, 32'h0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'hF, 4'hF, 4'd1, 4'd1, 32'h1, 32'h2);

        // Fill every word so later reads have a known answer; the reset row after resyncs outputs
        check_en = 1'b0;
        for (int a = 0; a < 16; a++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 4'hF, 4'h0, 4'(a), 4'd0, $urandom, 32'h0);
        end
        check_en = 1'b1;

        $display("[TB] directed table");
        for (int r = 0; r < 16; r++) begin
            applyStimulus(tbl[r].rst, tbl[r].ena, tbl[r].enb, tbl[r].wea, tbl[r].web,
                          tbl[r].addra, tbl[r].addrb, tbl[r].dia, tbl[r].dib);
            checkVal($sformatf("table row %0d", r),
                     {29'h0, vala_o[0], valb_o[0], coll_o[0], doa_o[0]} ^ {32'h0, dob_o[0]} << 0,
                     {29'h0, tbl[r].vala, tbl[r].valb, tbl[r].coll, tbl[r].doa} ^ {32'h0, tbl[r].dob} << 0);
            checkVal($sformatf("table row %0d dob", r), {32'h0, dob_o[0]}, {32'h0, tbl[r].dob});
        end

        $display("[TB] no-change write on d2 port A");
        applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'd5, 4'd0, 32'h0, 32'h0);
        checkVal("nc read", {31'h0, vala_o[1], doa_o[1]}, {31'h0, 1'b1, 32'hCAFEF00D});
        applyStimulus(1'b0, 1'b1, 1'b0, 4'hF, 4'h0, 4'd5, 4'd0, 32'h12345678, 32'h0);
        checkVal("nc write holds", {31'h0, vala_o[1], doa_o[1]}, {31'h0, 1'b0, 32'hCAFEF00D});
        applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'd5, 4'd0, 32'h0, 32'h0);
        checkVal("nc readback", {31'h0, vala_o[1], doa_o[1]}, {31'h0, 1'b1, 32'h12345678});

        $display("[TB] latency-2 streaming on d3");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 4'hF, 4'h0, 4'(i), 4'd0, 32'hA5000000 + 32'(i), 32'h0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'd0, 4'd0, 32'h0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'(i), 4'd0, 32'h0, 32'h0);
            if (i == 0) begin
                checkVal("stream first", {63'h0, vala_o[2]}, 64'h0);
            end else begin
                v = 32'hA5000000 + 32'(i - 1);
                checkVal($sformatf("stream %0d", i), {31'h0, vala_o[2], doa_o[2]}, {31'h0, 1'b1, v});
            end
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'd0, 4'd0, 32'h0, 32'h0);
        checkVal("stream last", {31'h0, vala_o[2], doa_o[2]}, {31'h0, 1'b1, 32'hA5000007});
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'd0, 4'd0, 32'h0, 32'h0);
        checkVal("stream end", {31'h0, vala_o[2], doa_o[2]}, {31'h0, 1'b0, 32'hA5000007});

        $display("[TB] reset mid-flight on d3");
        applyStimulus(1'b0, 1'b1, 1'b0, 4'hF, 4'h0, 4'd9, 4'd0, 32'hDEADBEEF, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'd0, 4'd0, 32'h0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'd0, 4'd0, 32'h0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'd9, 4'd0, 32'h0, 32'h0);
        checkVal("flight issued", {63'h0, vala_o[2]}, 64'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'd0, 4'd0, 32'h0, 32'h0);
        checkVal("flight reset", {30'h0, vala_o[2], coll_o[2], doa_o[2]}, 64'h0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'd0, 4'd0, 32'h0, 32'h0);
            checkVal($sformatf("after reset %0d", i), {31'h0, vala_o[2], doa_o[2]}, 64'h0);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'd9, 4'd0, 32'h0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'd0, 4'd0, 32'h0, 32'h0);
        checkVal("persist", {31'h0, vala_o[2], doa_o[2]}, {31'h0, 1'b1, 32'hDEADBEEF});

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            applyStimulus(($urandom_range(0, 49) == 0),
                          ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0,
                          ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0,
                          4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                          $urandom, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
